bulos_sink: RTL and testbench
=============================

// Module: bulos_sink
// PURPOSE
//  Receive-side partner of bulos. bulos emits a 2x2 packed nibble plus one XOR parity bit.
//  bulos_sink accepts these frames through a valid/ready handshake and checks even parity.
//  It buffers frames in a small FIFO and forwards each one downstream with a per-frame
//  error flag. It also keeps a saturating count of parity errors.
//  Sits between a bulos-style producer and any valid/ready consumer.
// PARAMETERS
//  DEPTH  4  FIFO entries; power of two, >=2
//  ERR_W  8  width of parity-error counter
// PORTS
//  clk        in   1                 single clock, rising edge
//  rst        in   1                 synchronous, active-high reset
//  in_valid   in   1                 producer presents a frame
//  in_ready   out  1                 sink can accept a frame this cycle
//  in_data    in   bit [3:2][1:2]    frame payload (nib_t)
//  in_par     in   1                 parity bit from producer
//  out_valid  out  1                 head-of-FIFO frame available
//  out_ready  in   1                 consumer takes frame
//  out_data   out  bit [3:2][1:2]    head frame payload
//  out_err    out  1                 head frame failed parity
//  err_clr    in   1                 synchronous clear of err_cnt
//  err_cnt    out  ERR_W             saturating parity-error count
//  level      out  $clog2(DEPTH)+1   current FIFO occupancy
// BEHAVIOUR
//  Reset, sampled on clk while rst=1:
//   - FIFO empties; out_valid=0, out_data=0, out_err=0, err_cnt=0, level=0.
//   - in_ready=0 while rst=1; in_ready=1 from the first cycle after rst falls.
//   - Reset mid-transfer discards all buffered frames; nothing is replayed.
//  Parity check:
//   - perr = ^in_data ^ in_par; perr=1 means error (even parity over 5 bits).
//   - perr is computed at the input and stored alongside the payload.
//  Push:
//   - Occurs when in_valid & in_ready.
//   - in_ready = !rst & (level != DEPTH).
//   - No push while full, even if a pop happens the same cycle (no full-bypass).
//  Pop:
//   - Occurs when out_valid & out_ready.
//   - out_valid = (level != 0).
//   - out_data/out_err come from registered FIFO head; stable while out_valid & !out_ready.
//  Latency: a frame pushed in cycle N is visible at out_valid in cycle N+1 at the earliest.
//   No combinational in->out path.
//  Simultaneous push and pop (not full, not empty): level unchanged, order preserved.
//  Pointers wrap modulo DEPTH. level counts 0..DEPTH inclusive.
//  err_cnt:
//   - Increments by 1 on each push with perr=1.
//   - Saturates at all-ones and holds.
//   - err_clr=1 forces 0 next cycle; clear wins over a coincident increment.
//  Frames with bad parity are still buffered and forwarded (flagged, never dropped).
//  Clean producer sequence, no handshake: a producer tying in_valid=1 is accepted only
//   while in_ready=1.
//  No FSM beyond FIFO occupancy states: EMPTY (level=0), PARTIAL, FULL (level=DEPTH).
// STRUCTURE
//  bulos_pkg:
//   - typedef bit [3:2][1:2] nib_t
//   - typedef struct packed {nib_t data; logic err;} frame_t
//   - localparam NIB_W=4
//  Sub-module bulos_sink_fifo:
//   - Generic frame_t FIFO with DEPTH parameter.
//   - Push/pop, level, full/empty outputs.
//  Top level holds the parity check, the handshake glue and the err_cnt register.
// TESTING
//  1. Reset: hold rst 3 cycles with in_valid=1.
//     -> in_ready=0, out_valid=0, err_cnt=0, level=0 throughout; in_ready=1 the cycle after.
//  2. Push in_data=4'b1010, in_par=0, then 4'b0111, in_par=0, out_ready=1.
//     -> outputs 1010 with out_err=0, then 0111 with out_err=1; err_cnt=1.
//  3. out_ready=0, push 5 frames with DEPTH=4.
//     -> 4 accepted, level=4, in_ready=0 on 5th; release out_ready -> FIFO order 1..4 preserved.
//  4. Simultaneous push/pop at level=2 for 10 cycles.
//     -> level stays 2; output sequence equals input sequence delayed by 2 frames.
//  5. ERR_W=2, push 5 bad-parity frames -> err_cnt 1,2,3,3,3.
//     Assert err_clr on the cycle of a 6th bad push -> err_cnt=0.
//  6. rst asserted with level=3 -> next cycle level=0, out_valid=0; buffered frames never appear.

Source files
------------

// File: rtl/bulos_pkg.sv
// Shared types for the bulos frame format: a 2x2 packed nibble plus its parity-check result.
package bulos_pkg;

    localparam int NIB_W = 4;

    typedef bit [3:2][1:2] nib_t;

    typedef struct packed {
        nib_t data;
        logic err;
    } frame_t;

endpackage

// File: rtl/bulos_sink_fifo.sv
// Small register-array FIFO of frame_t with occupancy, full and empty flags.
module bulos_sink_fifo
    import bulos_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  frame_t                     wr_frame,
    output frame_t                     rd_frame,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    frame_t          mem_q [DEPTH];
    frame_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;

    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    // Head is gated so the output reads as zero whenever nothing is buffered.
    assign rd_frame = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (push && (wr_ptr_q == PW'(i))) begin
                mem_d[i] = wr_frame;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/bulos_sink.sv
// Receive side of a bulos link: parity check, frame buffering and a saturating error count.
module bulos_sink
    import bulos_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ERR_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  nib_t                       in_data,
    input  logic                       in_par,
    output logic                       out_valid,
    input  logic                       out_ready,
    output nib_t                       out_data,
    output logic                       out_err,
    input  logic                       err_clr,
    output logic [ERR_W-1:0]           err_cnt,
    output logic [$clog2(DEPTH):0]     level
);

    logic [NIB_W-1:0] data_bits;
    logic             perr;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    frame_t           wr_frame;
    frame_t           rd_frame;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    assign data_bits = in_data;
    assign perr      = (^data_bits) ^ in_par;

    assign in_ready  = !rst && !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign wr_frame  = '{data: in_data, err: perr};
    assign out_data  = rd_frame.data;
    assign out_err   = rd_frame.err;
    assign err_cnt   = err_cnt_q;

    bulos_sink_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .wr_frame (wr_frame),
        .rd_frame (rd_frame),
        .level    (level),
        .full     (full),
        .empty    (empty)
    );

    // Clear takes priority over a same-cycle increment; the count sticks at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (push && perr && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_bulos_sink.sv
// Directed bench for bulos_sink with a frame scoreboard and a reference occupancy/error model.
module tb_bulos_sink;
    import bulos_pkg::*;

    localparam int DEPTH = 4;
    localparam int ERR_W = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    nib_t                   in_data;
    logic                   in_par;
    logic                   out_valid;
    logic                   out_ready;
    nib_t                   out_data;
    logic                   out_err;
    logic                   err_clr;
    logic [ERR_W-1:0]       err_cnt;
    logic [$clog2(DEPTH):0] level;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;
    logic [4:0] sb_q[$];

    always #5 clk = ~clk;

    bulos_sink #(
        .DEPTH (DEPTH),
        .ERR_W (ERR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_par    (in_par),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .err_clr   (err_clr),
        .err_cnt   (err_cnt),
        .level     (level)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic p, input logic ordy);
        in_valid  = v;
        in_data   = d;
        in_par    = p;
        out_ready = ordy;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
    task automatic tick();
        logic exp_ready, exp_valid, push, pop;
        logic [3:0] d;
        @(negedge clk);
        exp_ready = !rst && (sb_q.size() != DEPTH);
        exp_valid = (sb_q.size() != 0);
        check("in_ready",  32'(in_ready),  32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        check("level",     32'(level),     32'(sb_q.size()));
        check("err_cnt",   32'(err_cnt),   32'(exp_cnt));
        push = in_valid && exp_ready;
        pop  = exp_valid && out_ready;
        if (pop) begin
            check("out_data", 32'(out_data), 32'(sb_q[0][4:1]));
            check("out_err",  32'(out_err),  32'(sb_q[0][0]));
            $display("pop  data=%b err=%b level=%0d", out_data, out_err, level);
        end
        d = in_data;
        @(posedge clk);
        if (rst) begin
            sb_q.delete();
            exp_cnt = 0;
        end else begin
            if (pop) void'(sb_q.pop_front());
            if (push) sb_q.push_back({d, (^d) ^ in_par});
            if (err_clr) exp_cnt = 0;
            else if (push && ((^d) ^ in_par) && exp_cnt != (1 << ERR_W) - 1) exp_cnt++;
        end
        #1;
    endtask

    initial begin
        rst = 1'b1;
        err_clr = 1'b0;
        drive(1'b1, 4'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Reset held with a producer already presenting data
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        tick();

        // One good frame, one bad frame
        drive(1'b1, 4'b1010, 1'b0, 1'b1);
        tick();
        drive(1'b1, 4'b0111, 1'b0, 1'b1);
        tick();
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        tick();
        tick();

        // Fill past capacity, then drain in order
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 4'(i), (^4'(i)), 1'b0);
            tick();
        end
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) tick();

        // Steady streaming at level 2
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 4'(8 + i), 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 4'($urandom_range(15)), 1'($urandom_range(1)), 1'b1);
            tick();
        end
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick();

        // Error counter saturation and clear priority
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'b0001, 1'b0, 1'b1);
            tick();
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        tick();
        tick();

        // Reset with frames buffered; only the post-reset frame may emerge
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'(4 + i), 1'b0, 1'b0);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'hF, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
